easyaxi_rd_arb: RTL and testbench

Two-master to one-slave AXI read arbiter for the EasyAXI fabric. It sits between two read controllers of the EASYAXI_MST_RD_CTRL type and a single EASYAXI_SLV_RD_CTRL-type slave, in place of the direct AR/R wiring at top level. It grants one read burst at a time using round-robin priority and steers the slave's R beats back to the granted master. It also checks that the burst's beat count matches the granted ARLEN.

---
 rtl/easyaxi_rd_arb.sv | 219 +++++++++++++++++++++
 tb/tb_easyaxi_rd_arb.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/easyaxi_rd_arb.sv
// rtl/easyaxi_rd_arb.sv - two-master round-robin AXI read arbiter with burst length check
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif
`ifndef AXI_USER_W
`define AXI_USER_W 4
`endif

module easyaxi_rd_arb (
  input  logic                    clk,
  input  logic                    rst,
  // master 0
  input  logic                    axi_m0_arvalid,
  input  logic [`AXI_ID_W-1:0]    axi_m0_arid,
  input  logic [`AXI_ADDR_W-1:0]  axi_m0_araddr,
  input  logic [`AXI_LEN_W-1:0]   axi_m0_arlen,
  input  logic [`AXI_SIZE_W-1:0]  axi_m0_arsize,
  input  logic [`AXI_BURST_W-1:0] axi_m0_arburst,
  input  logic [`AXI_USER_W-1:0]  axi_m0_aruser,
  output logic                    axi_m0_arready,
  output logic                    axi_m0_rvalid,
  output logic [`AXI_ID_W-1:0]    axi_m0_rid,
  output logic [`AXI_DATA_W-1:0]  axi_m0_rdata,
  output logic [`AXI_RESP_W-1:0]  axi_m0_rresp,
  output logic                    axi_m0_rlast,
  output logic [`AXI_USER_W-1:0]  axi_m0_ruser,
  input  logic                    axi_m0_rready,
  // master 1
  input  logic                    axi_m1_arvalid,
  input  logic [`AXI_ID_W-1:0]    axi_m1_arid,
  input  logic [`AXI_ADDR_W-1:0]  axi_m1_araddr,
  input  logic [`AXI_LEN_W-1:0]   axi_m1_arlen,
  input  logic [`AXI_SIZE_W-1:0]  axi_m1_arsize,
  input  logic [`AXI_BURST_W-1:0] axi_m1_arburst,
  input  logic [`AXI_USER_W-1:0]  axi_m1_aruser,
  output logic                    axi_m1_arready,
  output logic                    axi_m1_rvalid,
  output logic [`AXI_ID_W-1:0]    axi_m1_rid,
  output logic [`AXI_DATA_W-1:0]  axi_m1_rdata,
  output logic [`AXI_RESP_W-1:0]  axi_m1_rresp,
  output logic                    axi_m1_rlast,
  output logic [`AXI_USER_W-1:0]  axi_m1_ruser,
  input  logic                    axi_m1_rready,
  // slave
  output logic                    axi_s_arvalid,
  output logic [`AXI_ID_W-1:0]    axi_s_arid,
  output logic [`AXI_ADDR_W-1:0]  axi_s_araddr,
  output logic [`AXI_LEN_W-1:0]   axi_s_arlen,
  output logic [`AXI_SIZE_W-1:0]  axi_s_arsize,
  output logic [`AXI_BURST_W-1:0] axi_s_arburst,
  output logic [`AXI_USER_W-1:0]  axi_s_aruser,
  input  logic                    axi_s_arready,
  input  logic                    axi_s_rvalid,
  input  logic [`AXI_ID_W-1:0]    axi_s_rid,
  input  logic [`AXI_DATA_W-1:0]  axi_s_rdata,
  input  logic [`AXI_RESP_W-1:0]  axi_s_rresp,
  input  logic                    axi_s_rlast,
  input  logic [`AXI_USER_W-1:0]  axi_s_ruser,
  output logic                    axi_s_rready,
  // status
  output logic                    busy,
  output logic                    grant,
  output logic                    len_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_grant;
  logic                   r_last_grant;
  logic                   r_len_err;
  logic [`AXI_LEN_W-1:0]  r_len_q;
  logic [`AXI_LEN_W:0]    r_beat_cnt;

  logic                   w_any_req;
  logic                   w_win;
  logic                   w_arvalid_sel;
  logic [`AXI_LEN_W-1:0]  w_arlen_sel;
  logic                   w_rready_sel;
  logic                   w_ar_hs;
  logic                   w_r_hs;
  logic                   w_len_hit;

  // On a tie the master that was not served last wins; otherwise the sole requester.
  assign w_any_req     = axi_m0_arvalid | axi_m1_arvalid;
  assign w_win         = (axi_m0_arvalid & axi_m1_arvalid) ? ~r_last_grant : axi_m1_arvalid;
  assign w_arvalid_sel = r_grant ? axi_m1_arvalid : axi_m0_arvalid;
  assign w_arlen_sel   = r_grant ? axi_m1_arlen   : axi_m0_arlen;
  assign w_rready_sel  = r_grant ? axi_m1_rready  : axi_m0_rready;
  assign w_ar_hs       = (r_state == ADDR) & w_arvalid_sel & axi_s_arready;
  assign w_r_hs        = (r_state == DATA) & axi_s_rvalid & w_rready_sel;
  assign w_len_hit     = (r_beat_cnt == {1'b0, r_len_q});

  assign busy    = (r_state != IDLE);
  assign grant   = r_grant;
  assign len_err = r_len_err;

  // State register, grant/round-robin history, beat counter and length-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_len_q      <= '0;
      r_beat_cnt   <= '0;
      r_len_err    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_len_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any_req) r_grant <= w_win;
        end
        ADDR: begin
          if (w_ar_hs) begin
            r_len_q    <= w_arlen_sel;
            r_beat_cnt <= '0;
          end
        end
        DATA: begin
          if (w_r_hs) begin
            r_beat_cnt <= r_beat_cnt + {{`AXI_LEN_W{1'b0}}, 1'b1};
            if (axi_s_rlast) begin
              r_last_grant <= r_grant;
              r_len_err    <= ~w_len_hit;
            end else if (w_len_hit) begin
              r_len_err    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next state plus the AR/R steering muxes; everything idles at zero by default.
  always_comb begin
    w_state_nxt    = r_state;
    axi_s_arvalid  = 1'b0;
    axi_s_arid     = '0;
    axi_s_araddr   = '0;
    axi_s_arlen    = '0;
    axi_s_arsize   = '0;
    axi_s_arburst  = '0;
    axi_s_aruser   = '0;
    axi_s_rready   = 1'b0;
    axi_m0_arready = 1'b0;
    axi_m1_arready = 1'b0;
    axi_m0_rvalid  = 1'b0;
    axi_m0_rid     = '0;
    axi_m0_rdata   = '0;
    axi_m0_rresp   = '0;
    axi_m0_rlast   = 1'b0;
    axi_m0_ruser   = '0;
    axi_m1_rvalid  = 1'b0;
    axi_m1_rid     = '0;
    axi_m1_rdata   = '0;
    axi_m1_rresp   = '0;
    axi_m1_rlast   = 1'b0;
    axi_m1_ruser   = '0;
    unique case (r_state)
      IDLE: begin
        if (w_any_req) w_state_nxt = ADDR;
      end
      ADDR: begin
        axi_s_arvalid = w_arvalid_sel;
        axi_s_arid    = r_grant ? axi_m1_arid    : axi_m0_arid;
        axi_s_araddr  = r_grant ? axi_m1_araddr  : axi_m0_araddr;
        axi_s_arlen   = w_arlen_sel;
        axi_s_arsize  = r_grant ? axi_m1_arsize  : axi_m0_arsize;
        axi_s_arburst = r_grant ? axi_m1_arburst : axi_m0_arburst;
        axi_s_aruser  = r_grant ? axi_m1_aruser  : axi_m0_aruser;
        if (r_grant) axi_m1_arready = axi_s_arready;
        else         axi_m0_arready = axi_s_arready;
        if (w_ar_hs) w_state_nxt = DATA;
      end
      DATA: begin
        axi_s_rready = w_rready_sel;
        if (r_grant) begin
          axi_m1_rvalid = axi_s_rvalid;
          axi_m1_rid    = axi_s_rid;
          axi_m1_rdata  = axi_s_rdata;
          axi_m1_rresp  = axi_s_rresp;
          axi_m1_rlast  = axi_s_rlast;
          axi_m1_ruser  = axi_s_ruser;
        end else begin
          axi_m0_rvalid = axi_s_rvalid;
          axi_m0_rid    = axi_s_rid;
          axi_m0_rdata  = axi_s_rdata;
          axi_m0_rresp  = axi_s_rresp;
          axi_m0_rlast  = axi_s_rlast;
          axi_m0_ruser  = axi_s_ruser;
        end
        if (w_r_hs && axi_s_rlast) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// tb/tb_easyaxi_rd_arb.sv - randomized self-checking bench for easyaxi_rd_arb
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif
`ifndef AXI_USER_W
`define AXI_USER_W 4
`endif

module tb_easyaxi_rd_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]              m_arvalid = 2'b00;
  logic [`AXI_ID_W-1:0]    m_arid    [2];
  logic [`AXI_ADDR_W-1:0]  m_araddr  [2];
  logic [`AXI_LEN_W-1:0]   m_arlen   [2];
  logic [`AXI_SIZE_W-1:0]  m_arsize  [2];
  logic [`AXI_BURST_W-1:0] m_arburst [2];
  logic [`AXI_USER_W-1:0]  m_aruser  [2];
  logic [1:0]              m_arready;
  logic [1:0]              m_rvalid;
  logic [`AXI_ID_W-1:0]    m_rid     [2];
  logic [`AXI_DATA_W-1:0]  m_rdata   [2];
  logic [`AXI_RESP_W-1:0]  m_rresp   [2];
  logic [1:0]              m_rlast;
  logic [`AXI_USER_W-1:0]  m_ruser   [2];
  logic [1:0]              m_rready = 2'b00;

  logic                    s_arvalid;
  logic [`AXI_ID_W-1:0]    s_arid;
  logic [`AXI_ADDR_W-1:0]  s_araddr;
  logic [`AXI_LEN_W-1:0]   s_arlen;
  logic [`AXI_SIZE_W-1:0]  s_arsize;
  logic [`AXI_BURST_W-1:0] s_arburst;
  logic [`AXI_USER_W-1:0]  s_aruser;
  logic                    s_arready = 1'b0;
  logic                    s_rvalid  = 1'b0;
  logic [`AXI_ID_W-1:0]    s_rid     = '0;
  logic [`AXI_DATA_W-1:0]  s_rdata   = '0;
  logic [`AXI_RESP_W-1:0]  s_rresp   = '0;
  logic                    s_rlast   = 1'b0;
  logic [`AXI_USER_W-1:0]  s_ruser   = '0;
  logic                    s_rready;

  logic busy, grant, len_err;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_last = 1;   // model of which master was served last

  easyaxi_rd_arb dut (
    .clk(clk), .rst(rst),
    .axi_m0_arvalid(m_arvalid[0]), .axi_m0_arid(m_arid[0]), .axi_m0_araddr(m_araddr[0]),
    .axi_m0_arlen(m_arlen[0]), .axi_m0_arsize(m_arsize[0]), .axi_m0_arburst(m_arburst[0]),
    .axi_m0_aruser(m_aruser[0]), .axi_m0_arready(m_arready[0]),
    .axi_m0_rvalid(m_rvalid[0]), .axi_m0_rid(m_rid[0]), .axi_m0_rdata(m_rdata[0]),
    .axi_m0_rresp(m_rresp[0]), .axi_m0_rlast(m_rlast[0]), .axi_m0_ruser(m_ruser[0]),
    .axi_m0_rready(m_rready[0]),
    .axi_m1_arvalid(m_arvalid[1]), .axi_m1_arid(m_arid[1]), .axi_m1_araddr(m_araddr[1]),
    .axi_m1_arlen(m_arlen[1]), .axi_m1_arsize(m_arsize[1]), .axi_m1_arburst(m_arburst[1]),
    .axi_m1_aruser(m_aruser[1]), .axi_m1_arready(m_arready[1]),
    .axi_m1_rvalid(m_rvalid[1]), .axi_m1_rid(m_rid[1]), .axi_m1_rdata(m_rdata[1]),
    .axi_m1_rresp(m_rresp[1]), .axi_m1_rlast(m_rlast[1]), .axi_m1_ruser(m_ruser[1]),
    .axi_m1_rready(m_rready[1]),
    .axi_s_arvalid(s_arvalid), .axi_s_arid(s_arid), .axi_s_araddr(s_araddr),
    .axi_s_arlen(s_arlen), .axi_s_arsize(s_arsize), .axi_s_arburst(s_arburst),
    .axi_s_aruser(s_aruser), .axi_s_arready(s_arready),
    .axi_s_rvalid(s_rvalid), .axi_s_rid(s_rid), .axi_s_rdata(s_rdata),
    .axi_s_rresp(s_rresp), .axi_s_rlast(s_rlast), .axi_s_ruser(s_ruser),
    .axi_s_rready(s_rready),
    .busy(busy), .grant(grant), .len_err(len_err)
  );

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic raise(input int m, input int len);
    m_arid[m]    = `AXI_ID_W'($urandom);
    m_araddr[m]  = `AXI_ADDR_W'($urandom);
    m_arlen[m]   = `AXI_LEN_W'(len);
    m_arsize[m]  = `AXI_SIZE_W'($urandom);
    m_arburst[m] = `AXI_BURST_W'($urandom);
    m_aruser[m]  = `AXI_USER_W'($urandom);
    m_arvalid[m] = 1'b1;
  endtask

  // One arbitrated burst. Called while the DUT is idle. delta moves rlast relative to arlen;
  // rst_after >= 0 resets the DUT before that beat index and returns early.
  task automatic do_burst(input bit req0, input bit req1, input int len, input int delta,
                          input int ar_delay, input bit toggle, input int rst_after,
                          output int win);
    int w, o, last, pulses, exp_pulses;
    bit ph, r, hs, e0, e1;
    logic [`AXI_DATA_W-1:0] d;
    logic [`AXI_ID_W-1:0]   id;
    logic [`AXI_USER_W-1:0] us;
    if (req0 && !m_arvalid[0]) raise(0, len);
    if (req1 && !m_arvalid[1]) raise(1, len);
    e0 = m_arvalid[0];
    e1 = m_arvalid[1];
    if (e0 && e1) w = 1 - exp_last;
    else          w = e1 ? 1 : 0;
    o = 1 - w;
    win = w;
    last = int'(m_arlen[w]) + delta;
    if (last < 0) last = 0;
    if (last > int'(m_arlen[w]))      exp_pulses = 2;
    else if (last < int'(m_arlen[w])) exp_pulses = 1;
    else                              exp_pulses = 0;

    // IDLE: slave offers a stray beat that must not be consumed or forwarded.
    s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = $urandom; m_rready = 2'b11;
    #1;
    if (s_arvalid !== 1'b0) begin n_fail++; $display("FAIL idle_s_arvalid got %0b want 0", s_arvalid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %0b want 0", busy); end
    n_checks++;
    if (m_rvalid !== 2'b00 || s_rready !== 1'b0) begin
      n_fail++; $display("FAIL idle_r_blocked rvalid=%b rready=%b want 00/0", m_rvalid, s_rready);
    end
    n_checks++;
    step();

    // ADDR: fields come from the winner, only the winner sees arready.
    for (int c = 0; c <= ar_delay; c++) begin
      s_arready = (c == ar_delay);
      #1;
      if (grant !== w[0] || busy !== 1'b1) begin
        n_fail++; $display("FAIL addr_grant grant=%0b busy=%0b want %0d/1", grant, busy, w);
      end
      n_checks++;
      if (s_arvalid !== 1'b1 || s_araddr !== m_araddr[w] || s_arid !== m_arid[w] ||
          s_arlen !== m_arlen[w] || s_aruser !== m_aruser[w] || s_arsize !== m_arsize[w]) begin
        n_fail++; $display("FAIL addr_fields arvalid=%0b addr=%h len=%0d want 1 %h %0d",
                           s_arvalid, s_araddr, s_arlen, m_araddr[w], m_arlen[w]);
      end
      n_checks++;
      if (m_arready[w] !== s_arready || m_arready[o] !== 1'b0) begin
        n_fail++; $display("FAIL addr_arready got %b slave_ready=%0b winner=%0d", m_arready, s_arready, w);
      end
      n_checks++;
      if (m_rvalid !== 2'b00 || s_rready !== 1'b0) begin
        n_fail++; $display("FAIL addr_r_blocked rvalid=%b rready=%b want 00/0", m_rvalid, s_rready);
      end
      n_checks++;
      step();
    end
    m_arvalid[w] = 1'b0;
    s_arready = 1'b0;

    // DATA: beats go to the winner only.
    pulses = 0;
    ph = 1'b0;
    for (int k = 0; k <= last; k++) begin
      if (k == rst_after) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        return;
      end
      d = $urandom; id = `AXI_ID_W'($urandom); us = `AXI_USER_W'($urandom);
      s_rvalid = 1'b1; s_rdata = d; s_rid = id; s_ruser = us; s_rlast = (k == last);
      hs = 1'b0;
      while (!hs) begin
        r = toggle ? ph : 1'b1;
        ph = ~ph;
        m_rready[w] = r;
        m_rready[o] = 1'b1;
        #1;
        if (m_rvalid[w] !== 1'b1 || m_rdata[w] !== d || m_rid[w] !== id ||
            m_ruser[w] !== us || m_rlast[w] !== s_rlast) begin
          n_fail++; $display("FAIL data_route beat=%0d rvalid=%0b data=%h want 1 %h", k, m_rvalid[w], m_rdata[w], d);
        end
        n_checks++;
        if (m_rvalid[o] !== 1'b0 || m_rdata[o] !== '0) begin
          n_fail++; $display("FAIL data_other beat=%0d rvalid=%0b data=%h want 0 0", k, m_rvalid[o], m_rdata[o]);
        end
        n_checks++;
        if (s_rready !== r || m_arready !== 2'b00) begin
          n_fail++; $display("FAIL data_ready s_rready=%0b arready=%b want %0b 00", s_rready, m_arready, r);
        end
        n_checks++;
        hs = r;
        step();
        if (len_err === 1'b1) pulses++;
      end
    end
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = 2'b00;
    #1;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL end_busy got %0b want 0", busy); end
    n_checks++;
    if (pulses != exp_pulses) begin
      n_fail++; $display("FAIL len_err_pulses got %0d want %0d (arlen=%0d last=%0d)", pulses, exp_pulses, m_arlen[w], last);
    end
    n_checks++;
    exp_last = w;
  endtask

  task automatic check_reset_outputs(input int tag);
    #1;
    if (busy !== 1'b0 || grant !== 1'b0 || len_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_status_%0d busy=%0b grant=%0b len_err=%0b want 0 0 0", tag, busy, grant, len_err);
    end
    n_checks++;
    if (s_arvalid !== 1'b0 || s_rready !== 1'b0 || m_arready !== 2'b00 || m_rvalid !== 2'b00) begin
      n_fail++; $display("FAIL reset_handshake_%0d s_arvalid=%0b s_rready=%0b arready=%b rvalid=%b want all 0",
                         tag, s_arvalid, s_rready, m_arready, m_rvalid);
    end
    n_checks++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_last = 1;
    check_reset_outputs(0);
  endtask

  task automatic test_single();
    int w;
    do_burst(1'b1, 1'b0, 3, 0, 0, 1'b0, -1, w);
  endtask

  task automatic test_tie();
    int w;
    rst = 1'b1; step(); rst = 1'b0; exp_last = 1;
    do_burst(1'b1, 1'b1, 0, 0, 0, 1'b0, -1, w);
    do_burst(1'b0, 1'b1, 0, 0, 0, 1'b0, -1, w);
  endtask

  task automatic test_round_robin();
    int w;
    for (int i = 0; i < 6; i++) do_burst(1'b1, 1'b1, 0, 0, 0, 1'b0, -1, w);
    while (m_arvalid != 2'b00) do_burst(1'b0, 1'b0, 0, 0, 0, 1'b0, -1, w);
  endtask

  task automatic test_backpressure();
    int w;
    do_burst(1'b0, 1'b1, 7, 0, 5, 1'b1, -1, w);
  endtask

  task automatic test_len_mismatch();
    int w;
    do_burst(1'b1, 1'b0, 3, -1, 0, 1'b0, -1, w);
    do_burst(1'b0, 1'b1, 3, 1, 1, 1'b1, -1, w);
  endtask

  task automatic test_reset_mid_burst();
    int w;
    do_burst(1'b1, 1'b0, 7, 0, 0, 1'b0, 2, w);
    exp_last = 1;
    check_reset_outputs(1);
    step();
    #1;
    if (m_rvalid !== 2'b00 || s_rready !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_no_forward rvalid=%b rready=%b want 00/0", m_rvalid, s_rready);
    end
    n_checks++;
    do_burst(1'b1, 1'b1, 1, 0, 0, 1'b0, -1, w);
    while (m_arvalid != 2'b00) do_burst(1'b0, 1'b0, 0, 0, 0, 1'b0, -1, w);
  endtask

  task automatic test_random();
    int w;
    bit r0, r1;
    for (int i = 0; i < 10; i++) begin
      r0 = 1'($urandom);
      r1 = r0 ? 1'($urandom) : 1'b1;
      do_burst(r0, r1, int'($urandom_range(0, 7)), int'($urandom_range(0, 2)) - 1,
               int'($urandom_range(0, 3)), 1'($urandom), -1, w);
    end
    while (m_arvalid != 2'b00) do_burst(1'b0, 1'b0, 0, 0, 0, 1'b0, -1, w);
  endtask

  // Guard against a stuck run.
  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Scenario sequence.
  initial begin
    for (int i = 0; i < 2; i++) begin
      m_arid[i] = '0; m_araddr[i] = '0; m_arlen[i] = '0;
      m_arsize[i] = '0; m_arburst[i] = '0; m_aruser[i] = '0;
    end
    test_reset();
    test_single();
    test_tie();
    test_round_robin();
    test_backpressure();
    test_len_mismatch();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
